// File: rtl/aes_cap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_cap_pkg
// Brief    : Shared widths, defaults and the capture-entry layout for the AES
//            ciphertext capture stage.
// Revision : 1.0 - initial release
// ============================================================================
package aes_cap_pkg;

    localparam int AES_BLK_W      = 128;
    localparam int AES_CAP_W      = 64;
    localparam int DEF_LATENCY    = 21;
    localparam int DEF_TAG_W      = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [AES_BLK_W-1:0] ct;
        logic [DEF_TAG_W-1:0] tag;
        logic [AES_CAP_W-1:0] leak;
    } cap_entry_t;

endpackage
`default_nettype wire

// File: rtl/aes_cap_fifo.sv
`default_nettype none
// ============================================================================
// Module   : aes_cap_fifo
// Brief    : Parameterised synchronous FIFO; a push into a full FIFO is taken
//            only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module aes_cap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = pop_i && (count_q != '0);
    assign w_push = push_i && ((count_q != CW'(DEPTH)) || w_pop);

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (w_push && !w_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!w_push && w_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/aes_ct_capture.sv
`default_nettype none
// ============================================================================
// Module   : aes_ct_capture
// Brief    : Tracks blocks issued to the pipelined AES core with a latency
//            matched {valid,tag} line, captures each ciphertext as it emerges
//            and drains it over ready/valid. Define CAPTURE_LEAK_EN to store
//            the core's Capacitance sample alongside each ciphertext.
// Revision : 1.0 - initial release
// ============================================================================
module aes_ct_capture
    import aes_cap_pkg::*;
#(
    parameter int LATENCY    = DEF_LATENCY,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TAG_W      = DEF_TAG_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          issue,
    input  logic [AES_BLK_W-1:0]          aes_out,
    input  logic [AES_CAP_W-1:0]          aes_cap,
    output logic                          ct_valid,
    input  logic                          ct_ready,
    output logic [AES_BLK_W-1:0]          ct_data,
    output logic [TAG_W-1:0]              ct_tag,
    output logic [AES_CAP_W-1:0]          ct_leak,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    logic [TAG_W-1:0]   tag_q;
    logic [TAG_W-1:0]   tag_d;
    logic               overflow_q;
    logic               overflow_d;
    logic [LATENCY-1:0] vld_q;
    logic [TAG_W-1:0]   dtag_q [LATENCY];

    logic               w_cap;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;

    assign w_cap = vld_q[LATENCY-1];
    assign w_pop = ct_valid && ct_ready;

    always_comb begin
        tag_d      = issue ? tag_q + 1'b1 : tag_q;
        overflow_d = overflow_q | (w_cap & w_full & ~w_pop);
    end

    // Clearing the whole delay line on reset drops every block still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q      <= '0;
            overflow_q <= 1'b0;
            vld_q      <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dtag_q[i] <= '0;
            end
        end else begin
            tag_q      <= tag_d;
            overflow_q <= overflow_d;
            vld_q[0]   <= issue;
            dtag_q[0]  <= tag_q;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                dtag_q[i] <= dtag_q[i-1];
            end
        end
    end

`ifdef CAPTURE_LEAK_EN
    localparam int ENT_W = AES_BLK_W + TAG_W + AES_CAP_W;
    logic [ENT_W-1:0] w_wdata;
    logic [ENT_W-1:0] w_rdata;

    assign w_wdata = {aes_out, dtag_q[LATENCY-1], aes_cap};
    assign ct_data = w_rdata[ENT_W-1 -: AES_BLK_W];
    assign ct_tag  = w_rdata[AES_CAP_W +: TAG_W];
    assign ct_leak = w_rdata[AES_CAP_W-1:0];
`else
    localparam int ENT_W = AES_BLK_W + TAG_W;
    logic [ENT_W-1:0] w_wdata;
    logic [ENT_W-1:0] w_rdata;
    logic             w_unused_cap;

    assign w_unused_cap = ^aes_cap;
    assign w_wdata      = {aes_out, dtag_q[LATENCY-1]};
    assign ct_data      = w_rdata[ENT_W-1 -: AES_BLK_W];
    assign ct_tag       = w_rdata[TAG_W-1:0];
    assign ct_leak      = '0;
`endif

    aes_cap_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_cap),
        .pop_i   (w_pop),
        .wdata_i (w_wdata),
        .rdata_o (w_rdata),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (fifo_count)
    );

    assign ct_valid = ~w_empty;
    assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_ct_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_ct_capture
// Brief    : Scoreboard bench for aes_ct_capture; emulates the AES core as a
//            fixed-latency pipe and checks against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_ct_capture;

    localparam int L     = 21;
    localparam int DEPTH = 4;
`ifdef CAPTURE_LEAK_EN
    localparam bit LEAK_ON = 1'b1;
`else
    localparam bit LEAK_ON = 1'b0;
`endif
    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ZERO_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    typedef struct {
        bit         v;
        bit [7:0]   tag;
        bit [127:0] ct;
        bit [63:0]  cap;
    } rec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         issue;
    logic         ct_ready;
    logic [127:0] aes_out;
    logic [63:0]  aes_cap;
    logic         ct_valid;
    logic [127:0] ct_data;
    logic [7:0]   ct_tag;
    logic [63:0]  ct_leak;
    logic [2:0]   fifo_count;
    logic         overflow;

    logic [127:0] nxt_ct;
    logic [63:0]  nxt_cap;

    int n_checks = 0;
    int n_fail   = 0;

    rec_t     hist[$];
    rec_t     mdl_q[$];
    rec_t     sb_q[$];
    bit [7:0] popped[$];
    int       mtag;
    bit       exp_ovf;

    always #5 clk = ~clk;

    aes_ct_capture dut (
        .clk        (clk),
        .rst        (rst),
        .issue      (issue),
        .aes_out    (aes_out),
        .aes_cap    (aes_cap),
        .ct_valid   (ct_valid),
        .ct_ready   (ct_ready),
        .ct_data    (ct_data),
        .ct_tag     (ct_tag),
        .ct_leak    (ct_leak),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model plus core emulation: every cycle is recorded; the record
    // from L cycles ago drives aes_out and, if it was a real block, lands in a
    // bounded FIFO model (drop + sticky overflow when no room).
    always @(negedge clk) begin
        rec_t r;
        rec_t a;
        bit   have;
        #1;
        if (rst) begin
            foreach (hist[i]) hist[i].v = 1'b0;
            mdl_q.delete();
            sb_q.delete();
            mtag    = 0;
            exp_ovf = 1'b0;
        end
        chk("fifo_count", fifo_count, mdl_q.size());
        chk("ct_valid", ct_valid, mdl_q.size() != 0);
        chk("overflow", overflow, exp_ovf);
        r.v   = issue && !rst;
        r.tag = 8'(mtag);
        r.ct  = nxt_ct;
        r.cap = nxt_cap;
        if (r.v) mtag = (mtag + 1) % 256;
        hist.push_back(r);
        have = 1'b0;
        if (hist.size() > L) begin
            a       = hist.pop_front();
            have    = a.v;
            aes_out = a.ct;
            aes_cap = a.cap;
        end else begin
            aes_out = rnd128();
            aes_cap = {$urandom, $urandom};
        end
        if (ct_ready && mdl_q.size() != 0) void'(mdl_q.pop_front());
        if (have) begin
            if (mdl_q.size() < DEPTH) begin
                mdl_q.push_back(a);
                sb_q.push_back(a);
            end else begin
                exp_ovf = 1'b1;
            end
        end
    end

    // Monitor: compares the presented head with the oldest expected entry.
    always @(negedge clk) begin
        rec_t e;
        if (ct_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got tag %h expected no output", ct_tag);
            end else begin
                e = sb_q[0];
                chk("ct_data", ct_data, e.ct);
                chk("ct_tag", ct_tag, e.tag);
                chk("ct_leak", ct_leak, LEAK_ON ? e.cap : 64'h0);
                if (ct_ready) begin
                    void'(sb_q.pop_front());
                    popped.push_back(e.tag);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            nxt_ct  = rnd128();
            nxt_cap = {$urandom, $urandom};
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        issue = 1'b0;
        cyc(2);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  issued;
        bit  ordered;
        bit  wrapped;
        rst      = 1'b0;
        issue    = 1'b0;
        ct_ready = 1'b0;
        aes_out  = '0;
        aes_cap  = '0;
        nxt_ct   = '0;
        nxt_cap  = '0;
        #2 rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", ct_valid, 0);
        chk("rst_data", ct_data, 0);
        chk("rst_tag", ct_tag, 0);
        chk("rst_leak", ct_leak, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);

        // Known-answer block with exact latency check
        cyc(1);
        issue  = 1'b1;
        nxt_ct = FIPS_CT;
        cyc(1);
        issue = 1'b0;
        cyc(20);
        @(negedge clk);
        chk("fips_early", ct_valid, 0);
        cyc(1);
        @(negedge clk);
        chk("fips_valid", ct_valid, 1);
        chk("fips_data", ct_data, FIPS_CT);
        chk("fips_tag", ct_tag, 0);

        // Zero-key vector takes the next tag
        cyc(1);
        ct_ready = 1'b1;
        cyc(1);
        issue  = 1'b1;
        nxt_ct = ZERO_CT;
        cyc(1);
        issue = 1'b0;
        cyc(20);
        @(negedge clk);
        cyc(1);
        @(negedge clk);
        chk("zero_valid", ct_valid, 1);
        chk("zero_data", ct_data, ZERO_CT);
        chk("zero_tag", ct_tag, 1);

        // Six back-to-back with consumer stalled: last two dropped
        cyc(2);
        ct_ready = 1'b0;
        do_reset();
        issue = 1'b1;
        cyc(6);
        issue = 1'b0;
        cyc(L + 2);
        @(negedge clk);
        chk("b2b_count", fifo_count, 4);
        chk("b2b_overflow", overflow, 1);
        popped.delete();
        cyc(1);
        ct_ready = 1'b1;
        cyc(6);
        @(negedge clk);
        chk("b2b_drained", fifo_count, 0);
        chk("b2b_ovf_sticky", overflow, 1);
        chk("b2b_npop", popped.size(), 4);
        for (int i = 0; i < 4 && i < popped.size(); i++) chk("b2b_order", popped[i], i);

        // Full FIFO, capture and pop on the same edge
        cyc(1);
        ct_ready = 1'b0;
        do_reset();
        issue = 1'b1;
        cyc(5);
        issue = 1'b0;
        cyc(L - 1);
        ct_ready = 1'b1;
        cyc(1);
        ct_ready = 1'b0;
        @(negedge clk);
        chk("fullpop_count", fifo_count, 4);
        chk("fullpop_overflow", overflow, 0);
        popped.delete();
        cyc(1);
        ct_ready = 1'b1;
        cyc(6);
        @(negedge clk);
        chk("fullpop_npop", popped.size(), 4);
        for (int i = 0; i < 4 && i < popped.size(); i++) chk("fullpop_order", popped[i], i + 1);

        // Reset while blocks are in flight discards them
        cyc(1);
        do_reset();
        issue = 1'b1;
        cyc(3);
        issue = 1'b0;
        cyc(5);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        popped.delete();
        cyc(L + 5);
        @(negedge clk);
        chk("rstflight_npop", popped.size(), 0);
        cyc(1);
        issue = 1'b1;
        cyc(1);
        issue = 1'b0;
        cyc(L + 3);
        @(negedge clk);
        chk("rstflight_after", popped.size(), 1);
        if (popped.size() > 0) chk("rstflight_tag", popped[0], 0);

        // Randomised traffic, 300 blocks: tag wrap and ordering
        cyc(1);
        do_reset();
        popped.delete();
        issued = 0;
        for (int c = 0; c < 5000 && issued < 300; c++) begin
            issue    = ($urandom_range(3) != 0);
            ct_ready = ($urandom_range(7) != 0);
            if (issue) issued++;
            cyc(1);
        end
        issue    = 1'b0;
        ct_ready = 1'b1;
        cyc(L + DEPTH + 5);
        @(negedge clk);
        chk("rand_issued", issued, 300);
        chk("rand_drained", fifo_count, 0);
        chk("rand_sb_empty", sb_q.size(), 0);
        ordered = 1'b1;
        wrapped = 1'b0;
        for (int i = 1; i < popped.size(); i++) begin
            if (popped[i] == popped[i-1]) ordered = 1'b0;
            if (popped[i] < popped[i-1]) wrapped = 1'b1;
        end
        chk("rand_order", ordered, 1);
        chk("rand_wrap", wrapped, 1);
        popped.delete();
        cyc(1);
        issue = 1'b1;
        cyc(1);
        issue = 1'b0;
        cyc(L + 3);
        @(negedge clk);
        chk("wrap_npop", popped.size(), 1);
        if (popped.size() > 0) chk("wrap_tag", popped[0], 300 % 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
